pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage of the RISCV_SingleCycle core, sitting directly downstream of branch_control.
- Consumes branch_taken, together with the jal/jalr decode flags and the immediate, to select the next PC.
- Drives a request/grant/rvalid instruction-memory port and presents one instruction at a time to decode.
- Raises a sticky trap and halts fetching on a misaligned control-transfer target.

---
 rtl/risc_pkg.sv | 27 ++
 rtl/adder.sv | 12 +
 rtl/next_pc_sel.sv | 52 +++++
 rtl/pc_fetch_unit.sv | 109 ++++++++++
 tb/tb_pc_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared types and constants for the RISCV_SingleCycle fetch path.
package risc_pkg;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
  localparam logic [31:0] ALIGN_MASK_JALR = 32'hFFFF_FFFE;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } pc_sel_t;

  // Without compressed instructions, a target is illegal when bit 1 is set.
  function automatic logic is_misaligned(input logic [31:0] target);
    return target[1];
  endfunction

endpackage

// File: rtl/adder.sv
// Plain modulo-2^W adder shared by the datapath.
module adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/next_pc_sel.sv
// Next-PC target selection (jalr > jal > branch > sequential) and misalignment detect.
module next_pc_sel
  import risc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            jal,
  input  logic            jalr,
  input  logic            branch_taken,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] rs1_imm;
  pc_sel_t         sel;

  adder #(.W(XLEN)) u_pc_imm  (.a(pc),       .b(imm), .y(pc_imm));
  adder #(.W(XLEN)) u_rs1_imm (.a(rs1_data), .b(imm), .y(rs1_imm));

  // Priority encode the redirect sources.
  always_comb begin
    sel = PC_SEQ;
    if (jalr) begin
      sel = PC_JALR;
    end else if (jal) begin
      sel = PC_JAL;
    end else if (branch_taken) begin
      sel = PC_BRANCH;
    end else begin
      sel = PC_SEQ;
    end
  end

  // Target mux; JALR clears bit 0 of its computed address.
  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      PC_JALR:           next_pc = rs1_imm & ALIGN_MASK_JALR;
      PC_JAL, PC_BRANCH: next_pc = pc_imm;
      PC_SEQ:            next_pc = pc_plus4;
      default:           next_pc = pc_plus4;
    endcase
  end

  assign misaligned = is_misaligned(next_pc);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, instruction-fetch FSM, retire counter and misaligned-target trap.
module pc_fetch_unit
  import risc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            trap_misaligned,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] instret
);

  fetch_state_t    state;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .jal          (jal),
    .jalr         (jalr),
    .branch_taken (branch_taken),
    .next_pc      (next_pc),
    .misaligned   (next_misaligned)
  );

  // Fetch FSM with registered request/valid outputs, PC update and trap capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pc              <= RESET_VECTOR;
      imem_req        <= 1'b0;
      instr_valid     <= 1'b0;
      instr           <= NOP_INSTR;
      trap_misaligned <= 1'b0;
      trap_pc         <= 32'h0000_0000;
      instret         <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (!stall) begin
            // The instruction retires even when its successor target is bad.
            instret     <= instret + 32'd1;
            instr_valid <= 1'b0;
            if (next_misaligned) begin
              trap_misaligned <= 1'b1;
              trap_pc         <= next_pc;
              state           <= HALT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= REQ;
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          // Unreachable encoding: park safely with no traffic.
          state       <= HALT;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: memory/decode driver plus independent valid monitor.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_VEC = 32'h0000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jal, jalr;
  logic [31:0] imm, rs1_data;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, trap_misaligned;
  logic [31:0] instr, pc, pc_plus4, trap_pc, instret;

  pc_fetch_unit #(.RESET_VECTOR(RST_VEC), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .jal(jal), .jalr(jalr), .imm(imm), .rs1_data(rs1_data),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .trap_misaligned(trap_misaligned), .trap_pc(trap_pc), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        last;
  int          total = 0;
  int          bad   = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  logic        m_trapped;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference next-PC rule, straight from the control-transfer definitions.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic j, input logic jr,
                                             input logic br, input logic [31:0] im,
                                             input logic [31:0] rs);
    if (jr) return (rs + im) & ~32'h1;
    if (j || br) return cur + im;
    return cur + 32'd4;
  endfunction

  // Monitor: each new instr_valid pops one expectation; while held, nothing may move.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid === 1'b1) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got instr_valid=1 want no pending fetch at %0t", $time);
          end else begin
            last = exp_q.pop_front();
            check("mon_pc", pc, last.pc);
            check("mon_instr", instr, last.instr);
            check("mon_instret", instret, last.cnt);
          end
        end else begin
          check("hold_pc", pc, last.pc);
          check("hold_instr", instr, last.instr);
          check("hold_instret", instret, last.cnt);
        end
      end
      prev_valid = (instr_valid === 1'b1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    jal = 1'b0; jalr = 1'b0; branch_taken = 1'b0;
    exp_q.delete();
    m_pc = RST_VEC; m_instret = 32'd0; m_trapped = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) check("req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  // Memory side: grant after gd cycles, return word rd cycles after the grant.
  task automatic fetch(input logic [31:0] word, input int gd, input int rd);
    wait_req();
    for (int i = 0; i < gd; i++) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      check("addr_hold", imem_addr, m_pc);
      @(negedge clk);
    end
    check("addr", imem_addr, m_pc);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    exp_q.push_back('{pc: m_pc, instr: word, cnt: m_instret});
    @(negedge clk);
    imem_gnt = 1'b0;
    check("req_drop", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < rd; i++) begin
      imem_rvalid = 1'b0;
      @(negedge clk);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    check("valid_lat", {31'd0, instr_valid}, 32'd1);
  endtask

  // Decode side: st stall cycles with random redirect noise, then retire.
  task automatic retire(input int st, input logic j, input logic jr, input logic br,
                        input logic [31:0] im, input logic [31:0] rs);
    logic [31:0] nxt;
    int n = 0;
    while (instr_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (instr_valid !== 1'b1) begin
      check("valid_timeout", {31'd0, instr_valid}, 32'd1);
      return;
    end
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    for (int i = 0; i < st; i++) begin
      stall = 1'b1;
      branch_taken = 1'($urandom_range(0, 1)); jal = 1'($urandom_range(0, 1));
      jalr = 1'($urandom_range(0, 1)); imm = $urandom; rs1_data = $urandom;
      imem_rvalid = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      @(negedge clk);
    end
    stall = 1'b0; jal = j; jalr = jr; branch_taken = br; imm = im; rs1_data = rs;
    imem_rvalid = 1'b0;
    nxt = model_next(m_pc, j, jr, br, im, rs);
    m_instret = m_instret + 32'd1;
    @(negedge clk);
    stall = 1'b1; jal = 1'b0; jalr = 1'b0; branch_taken = 1'b0;
    check("instret", instret, m_instret);
    if (nxt[1]) begin
      m_trapped = 1'b1;
      check("trap_flag", {31'd0, trap_misaligned}, 32'd1);
      check("trap_pc", trap_pc, nxt);
      check("trap_pc_hold", pc, m_pc);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("halt_req", {31'd0, imem_req}, 32'd0);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);
      end
    end else begin
      m_pc = nxt;
      check("next_pc", pc, m_pc);
      check("no_trap", {31'd0, trap_misaligned}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] r, im, rs;
    logic        j, jr, br;
    rst_n = 1'b0; stall = 1'b1; branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
    imm = 32'd0; rs1_data = 32'd0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    m_pc = RST_VEC; m_instret = 32'd0; m_trapped = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc, RST_VEC);
    check("rst_trap", {31'd0, trap_misaligned}, 32'd0);
    check("rst_trap_pc", trap_pc, 32'd0);
    check("rst_instret", instret, 32'd0);
    rst_n = 1'b1;

    // Minimum-latency first fetch, then sequential retires 0,4,8,12.
    fetch(32'h0050_0093, 0, 0);
    retire(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      fetch($urandom, 0, 1);
      retire(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    check("four_retired", instret, 32'd4);
    // Jump to 0x100, branch back by 8, walk forward to 0x100, jal+branch to 0x120.
    fetch($urandom, 1, 0); retire(0, 1'b1, 1'b0, 1'b0, 32'h0000_00F0, 32'd0);
    fetch($urandom, 0, 0); retire(0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'd0);
    check("branch_back", pc, 32'h0000_00F8);
    fetch($urandom, 0, 0); retire(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    fetch($urandom, 0, 0); retire(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    fetch($urandom, 0, 0); retire(0, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'd0);
    check("jal_branch", pc, 32'h0000_0120);
    // Five stalled cycles with redirect noise, then branch taken on release.
    fetch($urandom, 2, 2); retire(5, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'd0);
    check("stall_release", pc, 32'h0000_0160);
    // JALR to 0x1002 traps.
    fetch($urandom, 0, 0); retire(0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_1003);
    check("jalr_trapped", {31'd0, m_trapped}, 32'd1);
    do_reset();

    // Reset while a fetch is in WAIT; the late rvalid must be ignored.
    fetch($urandom, 0, 0); retire(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    fetch($urandom, 0, 0); retire(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_req();
    imem_gnt = 1'b0;
    repeat (3) @(negedge clk);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    imem_rvalid = 1'b0;
    check("late_rv_valid", {31'd0, instr_valid}, 32'd0);
    check("late_rv_instr", instr, NOP);
    m_pc = RST_VEC; m_instret = 32'd0; exp_q.delete();
    fetch(32'h0000_0013, 0, 0);
    retire(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 200; it++) begin
      r  = $urandom;
      im = {{20{r[11]}}, r[11:2], 2'b00};
      if ($urandom_range(0, 15) == 0) im[1] = 1'b1;
      rs = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) rs[1] = 1'b1;
      jr = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 2) == 0);
      br = 1'($urandom_range(0, 1));
      fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 2));
      retire($urandom_range(0, 3), j, jr, br, im, rs);
      if (m_trapped) do_reset();
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) check("queue_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
